// File: rtl/power_pkg.sv
// Shared state encoding and default timing constants for the thruster power sequencer.
package power_pkg;

    localparam int DEF_LEVEL_W           = 3;
    localparam int DEF_DEBOUNCE_CYCLES   = 500000;   // 10 ms at 50 MHz
    localparam int DEF_STEP_DWELL_CYCLES = 5000000;  // 100 ms at 50 MHz
    localparam int DEF_PGOOD_LOSS_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        DWELL,
        STEADY,
        FAULT
    } state_t;

endpackage

// File: rtl/power_sequencer_if.sv
// Board-side signal bundle of the power sequencer: raw switches and
// power-good in, mux select / kill / status out.
interface power_sequencer_if
    import power_pkg::*;
#(
    parameter int LEVEL_W = DEF_LEVEL_W
);

    logic [LEVEL_W-1:0] sw_level;
    logic               sw_enable;
    logic               power_good;
    logic               clear_fault;
    logic [LEVEL_W-1:0] voltage_mux;
    logic               kill_n;
    logic               busy;
    logic               fault;

    modport master (
        output sw_level, sw_enable, power_good, clear_fault,
        input  voltage_mux, kill_n, busy, fault
    );

    modport slave (
        input  sw_level, sw_enable, power_good, clear_fault,
        output voltage_mux, kill_n, busy, fault
    );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability counter. The whole bus is
// treated as one value: any bit change restarts the count, so all bits of
// the debounced output switch together.
module switch_debounce
    import power_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] last_p2;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_next;

    // Length of the current run of identical differing samples, including this one.
    always_comb begin
        run_next = CNT_W'(1);
        if (sync_p1 == last_p2) begin
            run_next = run_cnt + CNT_W'(1);
        end
    end

    // Synchronise, then accept a new value once it has been stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            last_p2 <= '0;
            run_cnt <= '0;
            dout    <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            last_p2 <= sync_p1;
            if (sync_p1 == dout) begin
                run_cnt <= '0;
            end else if (run_next >= CNT_LIMIT) begin
                dout    <= sync_p1;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_next;
            end
        end
    end

endmodule

// File: rtl/power_sequencer.sv
// Power sequencer: ramps the voltage-mux select one level at a time toward
// the debounced switch request, checks power-good after each step and
// latches a fault that drops the power path.
module power_sequencer
    import power_pkg::*;
#(
    parameter int LEVEL_W           = DEF_LEVEL_W,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_DWELL_CYCLES = DEF_STEP_DWELL_CYCLES,
    parameter int PGOOD_LOSS_CYCLES = DEF_PGOOD_LOSS_CYCLES
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    power_sequencer_if.slave   bus
);

    localparam int                 DWELL_W    = $clog2(STEP_DWELL_CYCLES) + 1;
    localparam int                 LOSS_W     = $clog2(PGOOD_LOSS_CYCLES) + 1;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(STEP_DWELL_CYCLES - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(PGOOD_LOSS_CYCLES - 1);

    logic [LEVEL_W:0]   sw_db;
    logic               en;
    logic [LEVEL_W-1:0] tgt;
    logic               pg_sync_p0;
    logic               pg;

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [LEVEL_W-1:0] mux_q;
    logic               kill_n_q;
    logic               busy_q;
    logic               fault_q;

    // Move one level toward the goal; never skips and never wraps.
    function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                       input logic [LEVEL_W-1:0] goal);
        logic [LEVEL_W-1:0] nxt;
        nxt = cur;
        if (goal > cur) begin
            nxt = cur + 1'b1;
        end else if (goal < cur) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    switch_debounce #(
        .WIDTH           (LEVEL_W + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .clk  (CLOCK_50),
        .rst  (reset),
        .din  ({bus.sw_enable, bus.sw_level}),
        .dout (sw_db)
    );

    assign en  = sw_db[LEVEL_W];
    assign tgt = sw_db[LEVEL_W-1:0];

    // power_good is only synchronised; its filtering is the loss counter below.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pg_sync_p0 <= 1'b0;
            pg         <= 1'b0;
        end else begin
            pg_sync_p0 <= bus.power_good;
            pg         <= pg_sync_p0;
        end
    end

    // Sequencing FSM with registered outputs; disable beats fault detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mux_q     <= '0;
            kill_n_q  <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            dwell_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (tgt == '0) begin
                            state    <= STEADY;
                            kill_n_q <= 1'b1;
                            loss_cnt <= '0;
                        end else begin
                            state  <= STEP;
                            busy_q <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (!en) begin
                        state    <= IDLE;
                        mux_q    <= '0;
                        kill_n_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        state     <= DWELL;
                        mux_q     <= step_toward(mux_q, tgt);
                        kill_n_q  <= 1'b1;
                        dwell_cnt <= DWELL_LOAD;
                    end
                end
                DWELL: begin
                    if (!en) begin
                        state    <= IDLE;
                        mux_q    <= '0;
                        kill_n_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (!pg) begin
                        state    <= FAULT;
                        mux_q    <= '0;
                        kill_n_q <= 1'b0;
                        busy_q   <= 1'b0;
                        fault_q  <= 1'b1;
                    end else if (mux_q != tgt) begin
                        state <= STEP;
                    end else begin
                        state    <= STEADY;
                        busy_q   <= 1'b0;
                        loss_cnt <= '0;
                    end
                end
                STEADY: begin
                    if (!en) begin
                        state    <= IDLE;
                        mux_q    <= '0;
                        kill_n_q <= 1'b0;
                    end else if (tgt != mux_q) begin
                        state  <= STEP;
                        busy_q <= 1'b1;
                    end else if (!pg) begin
                        if (loss_cnt == LOSS_LAST) begin
                            state    <= FAULT;
                            mux_q    <= '0;
                            kill_n_q <= 1'b0;
                            fault_q  <= 1'b1;
                        end else begin
                            loss_cnt <= loss_cnt + 1'b1;
                        end
                    end else begin
                        loss_cnt <= '0;
                    end
                end
                FAULT: begin
                    if (bus.clear_fault && !en) begin
                        state   <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mux_q    <= '0;
                    kill_n_q <= 1'b0;
                    busy_q   <= 1'b0;
                    fault_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.voltage_mux = mux_q;
    assign bus.kill_n      = kill_n_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed and randomised bench for power_sequencer with short timing
// parameters; ramps are predicted from the level-by-level timing rules.
module tb_power_sequencer;
    import power_pkg::*;

    localparam int LW        = 3;
    localparam int DEB       = 4;
    localparam int DW        = 8;
    localparam int PGL       = 4;
    localparam int FIRST_LAT = 2 + DEB + 1 + 1;  // raw change -> first mux move
    localparam int STEP_GAP  = DW + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         trace[$];
    logic [LW-1:0] last_vm = '0;

    power_sequencer_if #(.LEVEL_W(LW)) ifc ();

    power_sequencer #(
        .LEVEL_W           (LW),
        .DEBOUNCE_CYCLES   (DEB),
        .STEP_DWELL_CYCLES (DW),
        .PGOOD_LOSS_CYCLES (PGL)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every voltage_mux change with the clock count at which it appeared.
    always @(negedge clk) begin
        if (reset) begin
            last_vm <= '0;
        end else if (ifc.voltage_mux !== last_vm) begin
            trace.push_back(ev_t'{int'(cyc), int'(ifc.voltage_mux)});
            last_vm <= ifc.voltage_mux;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int vm, input int kn, input int bsy, input int flt);
        chk({tag, "_mux"},   ifc.voltage_mux, vm);
        chk({tag, "_kill"},  ifc.kill_n, kn);
        chk({tag, "_busy"},  ifc.busy, bsy);
        chk({tag, "_fault"}, ifc.fault, flt);
    endtask

    // Expected ramp: one level per step, first at FIRST_LAT, then every STEP_GAP.
    task automatic check_ramp(input string tag, input int from, input int to, input int c0);
        int n;
        int dir;
        n   = (to > from) ? to - from : from - to;
        dir = (to > from) ? 1 : -1;
        chk({tag, "_steps"}, trace.size(), n);
        for (int k = 1; k <= n; k++) begin
            if (k <= trace.size()) begin
                chk({tag, "_lvl"}, trace[k-1].val, from + dir * k);
                chk({tag, "_time"}, trace[k-1].cyc - c0, FIRST_LAT + (k - 1) * STEP_GAP);
            end
        end
    endtask

    initial begin
        int c0;
        int cur;
        int nxt;
        int d;
        int exp_v[4];

        ifc.sw_level    = '0;
        ifc.sw_enable   = 1'b0;
        ifc.power_good  = 1'b0;
        ifc.clear_fault = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk_out("reset", 0, 0, 0, 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk_out("idle", 0, 0, 0, 0);

        // Ramp up 0 -> 3
        trace.delete();
        c0 = int'(cyc);
        ifc.power_good = 1'b1;
        ifc.sw_level   = 3'd3;
        ifc.sw_enable  = 1'b1;
        tick(10);
        chk_out("up_e10", 1, 1, 1, 0);
        tick(10);
        chk_out("up_e20", 2, 1, 1, 0);
        tick(10);
        chk_out("up_e30", 3, 1, 1, 0);
        tick(5);
        chk_out("up_steady", 3, 1, 0, 0);
        check_ramp("ramp_up", 0, 3, c0);

        // Reversal: request 0, then 5 while dwelling at 2
        trace.delete();
        c0 = int'(cyc);
        ifc.sw_level = 3'd0;
        tick(8);
        chk("rev_first", ifc.voltage_mux, 2);
        ifc.sw_level = 3'd5;
        tick(9);
        chk("rev_turn", ifc.voltage_mux, 3);
        tick(27);
        chk_out("rev_steady", 5, 1, 0, 0);
        exp_v = '{2, 3, 4, 5};
        chk("rev_steps", trace.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < trace.size()) begin
                chk("rev_lvl", trace[k].val, exp_v[k]);
                chk("rev_time", trace[k].cyc - c0, FIRST_LAT + k * STEP_GAP);
            end
        end

        // Ramp down 5 -> 0
        trace.delete();
        c0 = int'(cyc);
        ifc.sw_level = 3'd0;
        tick(FIRST_LAT + 4 * STEP_GAP + 10);
        chk_out("down_steady", 0, 1, 0, 0);
        check_ramp("ramp_down", 5, 0, c0);

        // Debounce: 3-cycle glitch rejected, sustained change accepted
        trace.delete();
        ifc.sw_level = 3'd2;
        tick(3);
        ifc.sw_level = 3'd0;
        tick(12);
        chk("glitch_steps", trace.size(), 0);
        chk_out("glitch", 0, 1, 0, 0);
        ifc.sw_level = 3'd1;
        tick(FIRST_LAT);
        chk("hold_mux", ifc.voltage_mux, 1);
        tick(10);
        chk_out("hold_steady", 1, 1, 0, 0);

        // Disable from STEADY: exact raw-to-output latency
        ifc.sw_enable = 1'b0;
        tick(2 + DEB);
        chk("kill_before", ifc.kill_n, 1);
        tick(1);
        chk_out("kill_after", 0, 0, 0, 0);

        // Bouncing enable never reaches the power path
        for (int i = 0; i < 10; i++) begin
            ifc.sw_enable = (i % 2 == 0);
            tick(2);
            chk("bounce_kill", ifc.kill_n, 0);
        end
        ifc.sw_enable = 1'b0;
        tick(8);
        chk_out("bounce_end", 0, 0, 0, 0);

        // Power-good missing at the end of a step dwell
        ifc.sw_level  = 3'd1;
        ifc.sw_enable = 1'b1;
        tick(FIRST_LAT);
        chk_out("sf_step", 1, 1, 1, 0);
        ifc.power_good = 1'b0;
        tick(DW);
        chk_out("sf_fault", 0, 0, 0, 1);
        ifc.clear_fault = 1'b1;
        tick(1);
        ifc.clear_fault = 1'b0;
        tick(2);
        chk("sf_clr_en1", ifc.fault, 1);
        ifc.sw_enable  = 1'b0;
        ifc.power_good = 1'b1;
        tick(8);
        chk("sf_en0_hold", ifc.fault, 1);
        ifc.clear_fault = 1'b1;
        tick(1);
        ifc.clear_fault = 1'b0;
        chk_out("sf_cleared", 0, 0, 0, 0);

        // Steady power-good loss at level 4
        ifc.sw_level  = 3'd4;
        ifc.sw_enable = 1'b1;
        tick(FIRST_LAT + 3 * STEP_GAP + 10);
        chk_out("sl_steady", 4, 1, 0, 0);
        ifc.power_good = 1'b0;
        tick(PGL - 1);
        ifc.power_good = 1'b1;
        tick(8);
        chk_out("sl_short", 4, 1, 0, 0);
        ifc.power_good = 1'b0;
        tick(PGL);
        ifc.power_good = 1'b1;
        tick(4);
        chk_out("sl_fault", 0, 0, 0, 1);
        ifc.sw_enable = 1'b0;
        tick(8);
        ifc.clear_fault = 1'b1;
        tick(1);
        ifc.clear_fault = 1'b0;
        chk_out("sl_cleared", 0, 0, 0, 0);

        // Disable in the middle of a dwell
        ifc.sw_level  = 3'd2;
        ifc.sw_enable = 1'b1;
        tick(FIRST_LAT + 1);
        chk_out("kd_dwell", 1, 1, 1, 0);
        ifc.sw_enable = 1'b0;
        tick(2 + DEB);
        chk_out("kd_before", 1, 1, 1, 0);
        tick(1);
        chk_out("kd_after", 0, 0, 0, 0);

        // Asynchronous reset mid-ramp, checked before any clock edge
        ifc.sw_enable = 1'b1;
        tick(FIRST_LAT + 4);
        chk("ar_pre", ifc.voltage_mux, 1);
        #2 reset = 1'b1;
        #1;
        chk_out("ar_async", 0, 0, 0, 0);
        ifc.sw_level = 3'd0;
        tick(2);
        reset = 1'b0;
        tick(10);
        chk_out("ar_restart", 0, 1, 0, 0);

        // Randomised level requests against the ramp timing model
        cur = 0;
        for (int it = 0; it < 8; it++) begin
            nxt = int'($urandom_range(0, 7));
            d   = (nxt > cur) ? nxt - cur : cur - nxt;
            trace.delete();
            c0 = int'(cyc);
            ifc.sw_level = nxt[LW-1:0];
            tick(FIRST_LAT + d * STEP_GAP + 10);
            chk_out("rnd", nxt, 1, 0, 0);
            check_ramp("rnd_ramp", cur, nxt, c0);
            cur = nxt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
